// File: rtl/ram_cache_line_mover_pkg.sv
// Shared types and helpers for the cache-line mover: FSM state encoding,
// beat geometry and a beat-select helper used on the read path.
package ram_cache_mover_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_CAPTURE,
    RD_STREAM,
    WR_COLLECT,
    WR_COMMIT
  } state_e;

  localparam int BEAT_BITS  = 64;
  localparam int BEAT_BYTES = 8;

  // Widest line the helper accepts (16 beats); narrower lines are zero-extended.
  localparam int MAX_LINE_BITS     = 1024;
  localparam int MAX_BEAT_IDX_BITS = 4;

  // Returns beat 'idx' (64 bits) of a line.
  function automatic logic [BEAT_BITS-1:0] beat_select(
    input logic [MAX_LINE_BITS-1:0]     line,
    input logic [MAX_BEAT_IDX_BITS-1:0] idx
  );
    return line[BEAT_BITS*idx +: BEAT_BITS];
  endfunction

endpackage

// File: rtl/ram_cache_line_mover_if.sv
// Controller-facing channels of the cache-line mover: command, read-beat
// stream and write-beat stream. The mover takes the slave modport, the
// cache controller the master modport.
interface ram_cache_line_mover_if #(
  parameter int abits = 6,
  parameter int dbits = 128
);
  localparam int BEATS = dbits / 64;
  localparam int BW    = $clog2(BEATS);

  // Command channel
  logic             i_req_valid;
  logic             o_req_ready;
  logic             i_req_write;
  logic [abits-1:0] i_req_addr;
  logic [BW-1:0]    i_req_beat;

  // Read-beat channel (evict)
  logic             o_rd_valid;
  logic             i_rd_ready;
  logic [63:0]      o_rd_data;
  logic             o_rd_last;

  // Write-beat channel (fill)
  logic             i_wr_valid;
  logic             o_wr_ready;
  logic [63:0]      i_wr_data;
  logic [7:0]       i_wr_strb;
  logic             o_wr_done;

  modport slave (
    input  i_req_valid, i_req_write, i_req_addr, i_req_beat,
    input  i_rd_ready,
    input  i_wr_valid, i_wr_data, i_wr_strb,
    output o_req_ready,
    output o_rd_valid, o_rd_data, o_rd_last,
    output o_wr_ready, o_wr_done
  );

  modport master (
    output i_req_valid, i_req_write, i_req_addr, i_req_beat,
    output i_rd_ready,
    output i_wr_valid, i_wr_data, i_wr_strb,
    input  o_req_ready,
    input  o_rd_valid, o_rd_data, o_rd_last,
    input  o_wr_ready, o_wr_done
  );

endinterface

// File: rtl/ram_cache_line_mover.sv
// Cache-line mover: evicts a line by one RAM read streamed out as 64-bit
// beats, and fills a line by collecting strobed beats into one byte-masked
// RAM write. Optional feature macro: RAM_CACHE_MOVER_CRITICAL_FIRST_EN
// (reads start at the requested beat and wrap).
module ram_cache_line_mover
  import ram_cache_mover_pkg::*;
#(
  parameter int abits = 6,
  parameter int dbits = 128
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  ram_cache_line_mover_if.slave bus,
  output logic [abits-1:0]     o_ram_addr,
  output logic [dbits/8-1:0]   o_ram_wena,
  output logic [dbits-1:0]     o_ram_wdata,
  input  logic [dbits-1:0]     i_ram_rdata
);

  localparam int BEATS  = dbits / BEAT_BITS;
  localparam int BW     = $clog2(BEATS);
  localparam int NBYTES = dbits / 8;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_e            state, state_next;
  logic [abits-1:0]  r_addr;
  logic [dbits-1:0]  r_line;
  logic [NBYTES-1:0] r_mask;
  logic [BW-1:0]     r_beat;   // beat index presented on the read channel
  logic [BW-1:0]     r_cnt;    // beats transferred so far in this line

  logic          req_fire, rd_fire, wr_fire, cnt_last;
  logic [BW-1:0] start_beat, beat_next, cnt_next;

`ifdef RAM_CACHE_MOVER_CRITICAL_FIRST_EN
  assign start_beat = bus.i_req_beat;
`else
  logic unused_req_beat;
  assign unused_req_beat = ^bus.i_req_beat;
  assign start_beat      = '0;
`endif

  assign req_fire  = (state == IDLE)       && bus.i_req_valid;
  assign rd_fire   = (state == RD_STREAM)  && bus.i_rd_ready;
  assign wr_fire   = (state == WR_COLLECT) && bus.i_wr_valid;
  assign cnt_last  = (r_cnt == LAST_BEAT);
  assign beat_next = (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
  assign cnt_next  = cnt_last ? '0 : r_cnt + 1'b1;

  // State register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (!i_nrst) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode and all channel/RAM outputs, purely from state so an
  // async reset drops write enables without a clock edge.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_next      = state;
    bus.o_req_ready = 1'b0;
    bus.o_rd_valid  = 1'b0;
    bus.o_rd_data   = '0;
    bus.o_rd_last   = 1'b0;
    bus.o_wr_ready  = 1'b0;
    bus.o_wr_done   = 1'b0;
    o_ram_addr      = r_addr;
    o_ram_wena      = '0;
    o_ram_wdata     = '0;
    unique case (state)
      IDLE: begin
        bus.o_req_ready = 1'b1;
        if (bus.i_req_valid) state_next = bus.i_req_write ? WR_COLLECT : RD_REQ;
      end
      RD_REQ:     state_next = RD_CAPTURE;
      RD_CAPTURE: state_next = RD_STREAM;
      RD_STREAM: begin
        bus.o_rd_valid = 1'b1;
        bus.o_rd_data  = beat_select(MAX_LINE_BITS'(r_line), MAX_BEAT_IDX_BITS'(r_beat));
        bus.o_rd_last  = cnt_last;
        if (bus.i_rd_ready && cnt_last) state_next = IDLE;
      end
      WR_COLLECT: begin
        bus.o_wr_ready = 1'b1;
        if (bus.i_wr_valid && cnt_last) state_next = WR_COMMIT;
      end
      WR_COMMIT: begin
        o_ram_wena    = r_mask;
        o_ram_wdata   = r_line;
        bus.o_wr_done = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line buffer, byte mask, address and beat counters.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_addr <= '0;
      // NOTE: the line buffer is a plain register (not a RAM macro), so it
      // takes the reset like any other flop and reads as zero after reset.
      r_line <= '0;
      r_mask <= '0;
      r_beat <= '0;
      r_cnt  <= '0;
    end else begin
      if (req_fire) begin
        r_addr <= bus.i_req_addr;
        r_beat <= start_beat;
        r_cnt  <= '0;
        if (bus.i_req_write) r_mask <= '0;
      end
      if (state == RD_CAPTURE) begin
        r_line <= i_ram_rdata;
        r_cnt  <= '0;
      end
      if (rd_fire) begin
        r_beat <= beat_next;
        r_cnt  <= cnt_next;
      end
      if (wr_fire) begin
        for (int b = 0; b < BEAT_BYTES; b++) begin
          if (bus.i_wr_strb[b]) begin
            r_line[(int'(r_cnt)*BEAT_BYTES + b)*8 +: 8] <= bus.i_wr_data[b*8 +: 8];
            r_mask[int'(r_cnt)*BEAT_BYTES + b]          <= 1'b1;
          end
        end
        r_cnt <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_ram_cache_line_mover.sv
// Self-checking bench for ram_cache_line_mover (dbits=256, four beats).
// A byte-enable RAM sits beside the DUT; a line-level model (expected RAM
// contents plus queues of expected read beats and commits) is compared
// against the DUT outputs on every negative clock edge.
module tb_ram_cache_line_mover;

  localparam int ABITS  = 6;
  localparam int DBITS  = 256;
  localparam int BEATS  = DBITS / 64;
  localparam int NBYTES = DBITS / 8;
  localparam int DEPTH  = 1 << ABITS;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } rd_beat_t;

  typedef struct {
    logic [ABITS-1:0]  addr;
    logic [NBYTES-1:0] mask;
    logic [DBITS-1:0]  data;
  } commit_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_cache_line_mover_if #(.abits(ABITS), .dbits(DBITS)) bus ();

  logic [ABITS-1:0]  ram_addr;
  logic [NBYTES-1:0] ram_wena;
  logic [DBITS-1:0]  ram_wdata;
  logic [DBITS-1:0]  ram_rdata;

  ram_cache_line_mover #(.abits(ABITS), .dbits(DBITS)) dut (
    .i_clk       (clk),
    .i_nrst      (rst_n),
    .bus         (bus),
    .o_ram_addr  (ram_addr),
    .o_ram_wena  (ram_wena),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata)
  );

  // Byte-enable RAM with one cycle of read latency.
  logic [DBITS-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++)
      if (ram_wena[i]) ram_mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_rdata <= ram_mem[ram_addr];
  end

  // Reference model state.
  logic [DBITS-1:0] exp_mem [DEPTH];
  rd_beat_t         exp_rd[$];
  commit_t          exp_wr[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [DBITS-1:0] got, input logic [DBITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [DBITS-1:0] byte_mask(input logic [NBYTES-1:0] m);
    logic [DBITS-1:0] r;
    r = '0;
    for (int i = 0; i < NBYTES; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // Compare process: checks every beat and commit the DUT presents.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_rd_valid) begin
        if (exp_rd.size() == 0) begin
          check("rd_unexpected", DBITS'(bus.o_rd_data), '0);
        end else begin
          check("rd_data", DBITS'(bus.o_rd_data), DBITS'(exp_rd[0].data));
          check("rd_last", DBITS'(bus.o_rd_last), DBITS'(exp_rd[0].last));
          if (bus.i_rd_ready) void'(exp_rd.pop_front());
        end
      end else begin
        check("rd_last_idle", DBITS'(bus.o_rd_last), '0);
      end
      if (bus.o_wr_done) begin
        if (exp_wr.size() == 0) begin
          check("wr_done_unexpected", DBITS'(bus.o_wr_done), '0);
        end else begin
          check("commit_addr", DBITS'(ram_addr), DBITS'(exp_wr[0].addr));
          check("commit_wena", DBITS'(ram_wena), DBITS'(exp_wr[0].mask));
          check("commit_wdata", ram_wdata & byte_mask(exp_wr[0].mask),
                exp_wr[0].data & byte_mask(exp_wr[0].mask));
          void'(exp_wr.pop_front());
        end
      end else begin
        check("wena_idle", DBITS'(ram_wena), '0);
      end
      check("channel_excl", DBITS'(bus.o_rd_valid & bus.o_wr_ready), '0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Fill a line: beat b carries line[64*b +: 64] with strobes strb[8*b +: 8].
  task automatic do_write(input logic [ABITS-1:0] addr, input logic [DBITS-1:0] line,
                          input logic [NBYTES-1:0] strb, input bit gaps,
                          output logic [NBYTES-1:0] seen_wena);
    commit_t c;
    bus.i_req_valid = 1'b1;
    bus.i_req_write = 1'b1;
    bus.i_req_addr  = addr;
    bus.i_req_beat  = 2'($urandom);
    @(negedge clk);
    check("req_ready_wr", DBITS'(bus.o_req_ready), DBITS'(1));
    cyc();
    bus.i_req_valid = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc();
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = line[64*b +: 64];
      bus.i_wr_strb  = strb[8*b +: 8];
      @(negedge clk);
      check("wr_ready", DBITS'(bus.o_wr_ready), DBITS'(1));
      cyc();
      bus.i_wr_valid = 1'b0;
    end
    c.addr = addr;
    c.mask = strb;
    c.data = line;
    exp_wr.push_back(c);
    for (int i = 0; i < NBYTES; i++)
      if (strb[i]) exp_mem[addr][8*i +: 8] = line[8*i +: 8];
    @(negedge clk);
    check("wr_done_timing", DBITS'(bus.o_wr_done), DBITS'(1));
    seen_wena = ram_wena;
    cyc();
    @(negedge clk);
    check("ready_after_commit", DBITS'(bus.o_req_ready), DBITS'(1));
    check("wr_done_single", DBITS'(bus.o_wr_done), '0);
    cyc();
  endtask

  // Evict a line. mode 0: random ready; mode 1: ready 1,0,1 then held high.
  task automatic do_read(input logic [ABITS-1:0] addr, input logic [1:0] start,
                         input bit mode, output logic [63:0] first_data);
    int       n, got, vseen, lat;
    int       first;
    rd_beat_t e;
    first = start;
`ifndef RAM_CACHE_MOVER_CRITICAL_FIRST_EN
    first = 0;
`endif
    for (int k = 0; k < BEATS; k++) begin
      e.data = exp_mem[addr][64*((first + k) % BEATS) +: 64];
      e.last = (k == BEATS - 1);
      exp_rd.push_back(e);
    end
    bus.i_req_valid = 1'b1;
    bus.i_req_write = 1'b0;
    bus.i_req_addr  = addr;
    bus.i_req_beat  = start;
    bus.i_rd_ready  = 1'b0;
    @(negedge clk);
    check("req_ready_rd", DBITS'(bus.o_req_ready), DBITS'(1));
    cyc();
    bus.i_req_valid = 1'b0;
    n = 1; got = 0; vseen = 0; lat = 0; first_data = '0;
    while (got < BEATS && n < 200) begin
      if (mode) bus.i_rd_ready = (vseen != 1);
      else      bus.i_rd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.o_rd_valid) begin
        if (vseen == 0) begin
          lat = n;
          first_data = bus.o_rd_data;
        end
        vseen++;
        if (bus.i_rd_ready) got++;
      end
      cyc();
      n++;
    end
    bus.i_rd_ready = 1'b0;
    check("rd_beats_done", DBITS'(got), DBITS'(BEATS));
    check("rd_latency", DBITS'(lat), DBITS'(3));
    check("rd_queue_drained", DBITS'(exp_rd.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NBYTES-1:0] wena;
    logic [63:0]       fd;
    logic [DBITS-1:0]  lit, line;
    logic [NBYTES-1:0] strb;
    logic [ABITS-1:0]  a;

    for (int i = 0; i < DEPTH; i++) begin
      line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ram_mem[i] = line;
      exp_mem[i] = line;
    end
    bus.i_req_valid = 1'b0; bus.i_req_write = 1'b0; bus.i_req_addr = '0; bus.i_req_beat = '0;
    bus.i_rd_ready  = 1'b0; bus.i_wr_valid  = 1'b0; bus.i_wr_data  = '0; bus.i_wr_strb  = '0;

    // Reset state.
    #3;
    check("rst_req_ready", DBITS'(bus.o_req_ready), DBITS'(1));
    check("rst_rd_valid", DBITS'(bus.o_rd_valid), '0);
    check("rst_rd_data", DBITS'(bus.o_rd_data), '0);
    check("rst_wr_ready", DBITS'(bus.o_wr_ready), '0);
    check("rst_wr_done", DBITS'(bus.o_wr_done), '0);
    check("rst_ram_addr", DBITS'(ram_addr), '0);
    check("rst_ram_wena", DBITS'(ram_wena), '0);
    check("rst_ram_wdata", ram_wdata, '0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Full-strobe fill of line 5.
    lit = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    do_write(6'd5, lit, {NBYTES{1'b1}}, 1'b0, wena);
    check("full_wena_literal", DBITS'(wena), DBITS'(32'hFFFF_FFFF));
    check("full_model_literal", exp_mem[5], lit);
    check("full_ram_literal", ram_mem[5], lit);

    // Partial fill: only the low four bytes of beat 0 strobed.
    do_write(6'd5, {4{64'hAAAAAAAAAAAAAAAA}}, 32'h0000_000F, 1'b0, wena);
    lit = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h11111111AAAAAAAA};
    check("partial_wena_literal", DBITS'(wena), DBITS'(32'h0000_000F));
    check("partial_model_literal", exp_mem[5], lit);
    check("partial_ram_literal", ram_mem[5], lit);

    // Read with a stall on the second beat; requested start beat 2.
    do_read(6'd5, 2'd2, 1'b1, fd);
`ifdef RAM_CACHE_MOVER_CRITICAL_FIRST_EN
    check("first_beat_literal", DBITS'(fd), DBITS'(64'h3333333333333333));
`else
    check("first_beat_literal", DBITS'(fd), DBITS'(64'h11111111AAAAAAAA));
`endif
    do_read(6'd5, 2'd1, 1'b0, fd);

    // Async reset during a fill after one beat: nothing is committed.
    bus.i_req_valid = 1'b1; bus.i_req_write = 1'b1; bus.i_req_addr = 6'd9;
    cyc();
    bus.i_req_valid = 1'b0;
    bus.i_wr_valid = 1'b1; bus.i_wr_data = 64'hDEADBEEFDEADBEEF; bus.i_wr_strb = 8'hFF;
    cyc();
    bus.i_wr_data = 64'hCAFEF00DCAFEF00D;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_wena", DBITS'(ram_wena), '0);
    check("rst_mid_wr_done", DBITS'(bus.o_wr_done), '0);
    check("rst_mid_req_ready", DBITS'(bus.o_req_ready), DBITS'(1));
    check("rst_mid_wr_ready", DBITS'(bus.o_wr_ready), '0);
    bus.i_wr_valid = 1'b0;
    repeat (2) cyc();
    check("rst_hold_wena", DBITS'(ram_wena), '0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    do_read(6'd9, 2'd0, 1'b0, fd);
    check("rst_old_data", DBITS'(fd), DBITS'(exp_mem[9][63:0]));

    // Randomized traffic over a small address window.
    for (int t = 0; t < 60; t++) begin
      a = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 3))
          0:       strb = '1;
          1:       strb = '0;
          default: strb = $urandom;
        endcase
        do_write(a, line, strb, 1'b1, wena);
      end else begin
        do_read(a, 2'($urandom), 1'b0, fd);
      end
    end

    check("final_wr_queue", DBITS'(exp_wr.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
